// File: rtl/acc_pkg.sv
// Shared definitions for the ACC accumulation block and its tile sequencer.
package acc_pkg;

  localparam int unsigned ACC_LOG_MAX_ITERS          = 16;
  localparam int unsigned ACC_LOG_MAX_READS_PER_ITER = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } acc_seq_state_t;

endpackage

// File: rtl/acc_seq.sv
// acc_seq: tile sequencer driving the ACC configure interface.
// Latches one job (tiles, iterations, reads per iteration), pulses ACC
// configure once per tile and counts result beats to find the tile end.
// Optional build macro ACC_SEQ_PERF_EN adds saturating busy/stall counters.
module acc_seq
  import acc_pkg::*;
#(
  parameter int unsigned LOG_MAX_ITERS          = ACC_LOG_MAX_ITERS,
  parameter int unsigned LOG_MAX_READS_PER_ITER = ACC_LOG_MAX_READS_PER_ITER,
  parameter int unsigned LOG_MAX_TILES          = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [LOG_MAX_TILES-1:0]          num_tiles,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [LOG_MAX_TILES-1:0]          tile_idx,
  output logic                              acc_configure,
  output logic [LOG_MAX_ITERS-1:0]          acc_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] acc_num_reads_per_iter,
  input  logic                              acc_valid
`ifdef ACC_SEQ_PERF_EN
  ,
  output logic [31:0]                       perf_busy_cycles,
  output logic [31:0]                       perf_stall_cycles
`endif
);

  localparam logic [LOG_MAX_READS_PER_ITER-1:0] BEAT_ONE = LOG_MAX_READS_PER_ITER'(1);
  localparam logic [LOG_MAX_TILES:0]            TILE_ONE = (LOG_MAX_TILES+1)'(1);

  acc_seq_state_t                    state_q;
  logic [LOG_MAX_TILES-1:0]          tiles_q;
  logic [LOG_MAX_TILES-1:0]          tile_idx_q;
  logic [LOG_MAX_ITERS-1:0]          iters_q;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_q;
  logic [LOG_MAX_READS_PER_ITER-1:0] beat_q;
  logic                              busy_q;
  logic                              done_q;
  logic                              err_q;
  logic                              cfg_q;
  logic [LOG_MAX_TILES:0]            tile_nxt;
  logic                              zero_job;

  // Widened by one bit so the last-tile compare never wraps at full-scale num_tiles.
  assign tile_nxt = {1'b0, tile_idx_q} + TILE_ONE;
  assign zero_job = (num_tiles == '0) || (num_iters == '0) || (num_reads_per_iter == '0);

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tiles_q    <= '0;
      tile_idx_q <= '0;
      iters_q    <= '0;
      reads_q    <= '0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cfg_q      <= 1'b0;
    end else if (abort && (state_q != ST_IDLE)) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cfg_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (acc_valid) err_q <= 1'b1;
          if (start) begin
            tiles_q    <= num_tiles;
            iters_q    <= num_iters;
            reads_q    <= num_reads_per_iter;
            tile_idx_q <= '0;
            err_q      <= acc_valid;
            busy_q     <= 1'b1;
            if (zero_job) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CONFIG;
              cfg_q   <= 1'b1;
            end
          end
        end
        ST_CONFIG: begin
          if (acc_valid) err_q <= 1'b1;
          beat_q  <= reads_q;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (acc_valid) begin
            if (beat_q == BEAT_ONE) begin
              if (tile_nxt < {1'b0, tiles_q}) begin
                tile_idx_q <= tile_nxt[LOG_MAX_TILES-1:0];
                state_q    <= ST_CONFIG;
                cfg_q      <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              beat_q <= beat_q - BEAT_ONE;
            end
          end
        end
        ST_DONE: begin
          if (acc_valid) err_q <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign err                    = err_q;
  assign tile_idx               = tile_idx_q;
  assign acc_configure          = cfg_q;
  assign acc_num_iters          = iters_q;
  assign acc_num_reads_per_iter = reads_q;

`ifdef ACC_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  // Saturating busy/stall counters, cleared by each accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if ((state_q == ST_RUN) && !acc_valid && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_acc_seq.sv
// Self-checking bench for acc_seq: directed jobs from the test plan plus
// randomized jobs, checked cycle by cycle against a job-timeline model.
module tb_acc_seq;

  localparam int P_CFG   = 0;
  localparam int P_RUN   = 1;
  localparam int P_DONE  = 2;
  localparam int P_END   = 3;
  localparam int P_AFTER = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_tiles;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] tile_idx;
  logic        acc_configure;
  logic [15:0] acc_num_iters;
  logic [15:0] acc_num_reads_per_iter;
  logic        acc_valid;
`ifdef ACC_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Values the outputs must hold while idle.
  bit          exp_err    = 1'b0;
  int unsigned last_tile  = 0;
  int unsigned last_iters = 0;
  int unsigned last_reads = 0;

  always #5 clk = ~clk;

  acc_seq #(
    .LOG_MAX_ITERS         (16),
    .LOG_MAX_READS_PER_ITER(16),
    .LOG_MAX_TILES         (16)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .abort                 (abort),
    .num_tiles             (num_tiles),
    .num_iters             (num_iters),
    .num_reads_per_iter    (num_reads_per_iter),
    .busy                  (busy),
    .done                  (done),
    .err                   (err),
    .tile_idx              (tile_idx),
    .acc_configure         (acc_configure),
    .acc_num_iters         (acc_num_iters),
    .acc_num_reads_per_iter(acc_num_reads_per_iter),
    .acc_valid             (acc_valid)
`ifdef ACC_SEQ_PERF_EN
    ,
    .perf_busy_cycles      (perf_busy_cycles),
    .perf_stall_cycles     (perf_stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string ph, input bit b, input bit d, input bit c,
                            input int unsigned t, input bit e,
                            input int unsigned it, input int unsigned rd);
    check_eq({ph, ".busy"}, busy, b);
    check_eq({ph, ".done"}, done, d);
    check_eq({ph, ".cfg"}, acc_configure, c);
    check_eq({ph, ".tile"}, tile_idx, t);
    check_eq({ph, ".err"}, err, e);
    check_eq({ph, ".iters"}, acc_num_iters, it);
    check_eq({ph, ".reads"}, acc_num_reads_per_iter, rd);
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; acc_valid = 1'b0; abort = 1'b0;
      check_outs("idle", 1'b0, 1'b0, 1'b0, last_tile, exp_err, last_iters, last_reads);
    end
  endtask

  // mode 0: run to completion; 1: abort when trig beats have been issued; 2: reset instead.
  task automatic run_job(input int unsigned tiles, input int unsigned iters,
                         input int unsigned reads, input int mode, input int unsigned trig);
    int unsigned k = 0, nb = 0, total = 0, busy_n = 0, stall_n = 0, guard = 0;
    int phase;
    @(negedge clk);
    start = 1'b1; acc_valid = 1'b0; abort = 1'b0;
    num_tiles = 16'(tiles); num_iters = 16'(iters); num_reads_per_iter = 16'(reads);
    exp_err = 1'b0;
    phase = (tiles == 0 || iters == 0 || reads == 0) ? P_DONE : P_CFG;
    forever begin
      @(negedge clk);
      start = 1'b0; acc_valid = 1'b0; abort = 1'b0; rst = 1'b1;
      // Job fields are latched only on acceptance; scramble them while busy.
      num_tiles = 16'($urandom); num_iters = 16'($urandom); num_reads_per_iter = 16'($urandom);
      guard++;
      if (guard > 4000) begin
        check_eq("job_timeout", 32'd1, 32'd0);
        break;
      end
      if (phase == P_CFG) begin
        check_outs("cfg", 1'b1, 1'b0, 1'b1, k, 1'b0, iters, reads);
        busy_n++;
        phase = P_RUN;
        start = ($urandom_range(0, 3) == 0);
      end else if (phase == P_RUN) begin
        check_outs("run", 1'b1, 1'b0, 1'b0, k, 1'b0, iters, reads);
        busy_n++;
        start = ($urandom_range(0, 3) == 0);
        if (mode != 0 && total == trig) begin
          if (mode == 1) abort = 1'b1;
          else rst = 1'b0;
          stall_n++;
          phase = P_AFTER;
        end else if ($urandom_range(0, 2) != 0) begin
          acc_valid = 1'b1;
          total++;
          nb++;
          if (nb == reads) begin
            nb = 0;
            if (k + 1 < tiles) begin
              k++;
              phase = P_CFG;
            end else begin
              phase = P_DONE;
            end
          end
        end else begin
          stall_n++;
        end
      end else if (phase == P_DONE) begin
        check_outs("done", 1'b1, 1'b1, 1'b0, k, 1'b0, iters, reads);
        busy_n++;
        phase = P_END;
        start = ($urandom_range(0, 1) == 0);
      end else if (phase == P_END) begin
        check_outs("end", 1'b0, 1'b0, 1'b0, k, 1'b0, iters, reads);
`ifdef ACC_SEQ_PERF_EN
        check_eq("perf_busy", perf_busy_cycles, busy_n);
        check_eq("perf_stall", perf_stall_cycles, stall_n);
`endif
        last_tile = k; last_iters = iters; last_reads = reads;
        break;
      end else begin
        if (mode == 1) begin
          check_outs("abort", 1'b0, 1'b0, 1'b0, k, 1'b0, iters, reads);
`ifdef ACC_SEQ_PERF_EN
          check_eq("abort_perf_busy", perf_busy_cycles, busy_n);
          check_eq("abort_perf_stall", perf_stall_cycles, stall_n);
`endif
          last_tile = k; last_iters = iters; last_reads = reads;
        end else begin
          check_outs("rst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
`ifdef ACC_SEQ_PERF_EN
          check_eq("rst_perf_busy", perf_busy_cycles, 0);
          check_eq("rst_perf_stall", perf_stall_cycles, 0);
`endif
          last_tile = 0; last_iters = 0; last_reads = 0;
        end
        break;
      end
    end
  endtask

  initial begin
    int unsigned rt, ri, rr;
    rst = 1'b0; start = 1'b0; abort = 1'b0; acc_valid = 1'b0;
    num_tiles = '0; num_iters = '0; num_reads_per_iter = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);

    run_job(2, 3, 4, 0, 0);
    idle_cycles(2);
    run_job(1, 1, 1, 0, 0);
    run_job(3, 2, 0, 0, 0);
    idle_cycles(1);

    // Stray beat while idle raises a sticky err that only a new start clears.
    @(negedge clk);
    acc_valid = 1'b1;
    exp_err = 1'b1;
    idle_cycles(4);
    run_job(1, 5, 2, 0, 0);

    // Abort in tile 1 of 3 after two of its beats, then a clean job.
    run_job(3, 2, 3, 1, 5);
    idle_cycles(3);
    run_job(2, 2, 2, 0, 0);
    run_job(2, 7, 3, 1, 0);
    idle_cycles(1);

    // One-cycle reset mid-RUN, then a fresh job.
    run_job(2, 4, 3, 2, 4);
    idle_cycles(2);
    run_job(2, 2, 2, 0, 0);

    for (int unsigned j = 0; j < 16; j++) begin
      rt = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 4);
      ri = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 65535);
      rr = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 5);
      if ($urandom_range(0, 4) == 0) run_job(rt, ri, rr, 1, $urandom_range(0, 3));
      else run_job(rt, ri, rr, 0, 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
